program_sequencer_pipe: RTL

PROGRAM_SEQUENCER_PIPE -- requirements
Module: program_sequencer_pipe

---
 rtl/program_sequencer_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/program_sequencer_pipe.sv
// Two-stage instruction fetch sequencer for a synchronous program ROM.
// It has fill/flush control, a jump penalty of 2 bubbles, and a stall hold.
module program_sequencer_pipe (
    input  logic       clk,
    input  logic       reset,
    input  logic       jmp,
    input  logic       jmp_nz,
    input  logic       dont_jmp,
    input  logic [3:0] jmp_addr,
    input  logic       stall,
    input  logic [7:0] rom_data,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic       ir_valid,
    output logic       flush_pipeline
);

    typedef enum logic [2:0] {
        FILL0  = 3'd0,
        FILL1  = 3'd1,
        RUN    = 3'd2,
        FLUSH1 = 3'd3,
        FLUSH2 = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pm_addr_q, pm_addr_d;
    logic [7:0] f_addr_q, f_addr_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       ir_valid_q, ir_valid_d;
    logic       flush_q, flush_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic       jump_taken_s;
    logic [7:0] fetch_data_s;

    // Next-state, fetch and stall-hold logic.
    always_comb begin
        state_d      = state_q;
        pm_addr_d    = pm_addr_q;
        f_addr_d     = f_addr_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        ir_valid_d   = ir_valid_q;
        flush_d      = flush_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;

        jump_taken_s = ir_valid_q & ~stall & (jmp | (jmp_nz & ~dont_jmp));
        // The ROM keeps re-reading the held pm_addr during a stall, so the word
        // that belongs to f_addr is parked here and replayed on resume.
        fetch_data_s = hold_valid_q ? hold_q : rom_data;

        if (stall) begin
            hold_valid_d = 1'b1;
            if (!hold_valid_q) begin
                hold_d = rom_data;
            end else begin
                hold_d = hold_q;
            end
        end else begin
            hold_valid_d = 1'b0;
            f_addr_d     = pm_addr_q;
            ir_d         = fetch_data_s;
            pc_d         = f_addr_q;
            if (jump_taken_s) begin
                pm_addr_d = {jmp_addr, 4'h0};
            end else begin
                pm_addr_d = pm_addr_q + 8'd1;
            end

            case (state_q)
                FILL0:   state_d = FILL1;
                FILL1:   state_d = RUN;
                RUN: begin
                    if (jump_taken_s) begin
                        state_d = FLUSH1;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH1:  state_d = FLUSH2;
                FLUSH2:  state_d = RUN;
                default: state_d = FILL0;
            endcase

            ir_valid_d = (state_d == RUN);
            flush_d    = (state_d == FLUSH1) || (state_d == FLUSH2);
        end
    end

    // State and pipeline registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL0;
            pm_addr_q    <= 8'h00;
            f_addr_q     <= 8'h00;
            pc_q         <= 8'h00;
            ir_q         <= 8'h00;
            ir_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pm_addr_q    <= pm_addr_d;
            f_addr_q     <= f_addr_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            flush_q      <= flush_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign pm_addr        = pm_addr_q;
    assign pc             = pc_q;
    assign ir             = ir_q;
    assign ir_valid       = ir_valid_q;
    assign flush_pipeline = flush_q;

endmodule
